pipe_skid: RTL and testbench

- Elastic pipeline stage between two adjacent CPU pipeline stages, e.g. fetch to decode or decode to execute.
- Uses a valid/ready handshake with a 2-entry skid buffer, so `in_ready` is fully registered and no combinational ready path crosses the stage.
- Supports a synchronous flush for branch or exception squash.
- Output data is registered and feeds the next stage's datapath directly.

---
 rtl/pipe_skid_pkg.sv | 12 +
 rtl/pipe_skid.sv | 84 ++++++++
 tb/tb_pipe_skid.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipe_skid_pkg.sv
// Shared state encodings for elastic valid/ready pipeline stages.
package pipe_skid_pkg;

  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] pipe_state_t;

  localparam logic [1:0] PIPE_EMPTY = 2'd0;
  localparam logic [1:0] PIPE_FULL  = 2'd1;
  localparam logic [1:0] PIPE_SKID  = 2'd2;

endpackage

// File: rtl/pipe_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer: registered in_ready,
// registered out_valid/out_data, synchronous reset and flush.
module pipe_skid
  import pipe_skid_pkg::*;
#(
  parameter int unsigned       width      = 32,
  parameter logic [width-1:0]  flush_data = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data
);

  pipe_state_t      state_q, state_d;
  logic [width-1:0] main_q, main_d;
  logic [width-1:0] skid_q, skid_d;
  logic             out_valid_q, in_ready_q;

  // Next-state and datapath selection; flush squashes everything held.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PIPE_EMPTY;
      main_d  = flush_data;
      skid_d  = flush_data;
    end else begin
      case (state_q)
        PIPE_EMPTY: begin
          if (in_valid) begin
            main_d  = in_data;
            state_d = PIPE_FULL;
          end
        end
        PIPE_FULL: begin
          if (in_valid && out_ready) begin
            main_d = in_data;
          end else if (out_ready) begin
            state_d = PIPE_EMPTY;
          end else if (in_valid) begin
            skid_d  = in_data;
            state_d = PIPE_SKID;
          end
        end
        PIPE_SKID: begin
          if (out_ready) begin
            main_d  = skid_q;
            state_d = PIPE_FULL;
          end
        end
        default: state_d = PIPE_EMPTY;
      endcase
    end
  end

  // Handshake flags are flopped from the next state so no path crosses the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PIPE_EMPTY;
      main_q      <= flush_data;
      skid_q      <= flush_data;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != PIPE_EMPTY);
      in_ready_q  <= (state_d != PIPE_SKID);
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid.sv
// Scoreboard bench for pipe_skid: directed scenarios followed by random traffic.
module tb_pipe_skid;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_data, out_data;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_main = 32'h0;
  bit          started = 1'b0;

  always #5 clk = ~clk;

  pipe_skid dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, model the handshakes at negedge, check after the edge.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy,
                      input logic fl, input logic rs);
    logic ir0;
    ir0       = in_ready;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    #1;
    if (started) chk("in_ready_no_comb_path", {31'b0, in_ready}, {31'b0, ir0});
    @(negedge clk);
    if (rs) begin
      exp_q.delete();
      exp_main = 32'h0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) begin
          chk("out_beat", out_data, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          chk("unexpected_beat", {31'b0, out_valid}, 32'h0);
        end
      end
      if (fl) begin
        exp_q.delete();
        exp_main = 32'h0;
      end else if (in_valid && in_ready) begin
        exp_q.push_back(d);
      end
      if (exp_q.size() != 0) exp_main = exp_q[0];
    end
    @(posedge clk);
    #1;
    started = 1'b1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() != 0)});
    chk("in_ready",  {31'b0, in_ready},  {31'b0, (exp_q.size() < 2)});
    chk("out_data",  out_data, exp_main);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;
    @(posedge clk);
    #1;
    // Reset
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    // Stream at full rate
    step(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    chk("latency_valid", {31'b0, out_valid}, 32'h1);
    step(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);
    // Backpressure into the skid entry
    step(1'b1, 32'hA0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0);
    chk("skid_in_ready", {31'b0, in_ready}, 32'h0);
    step(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);
    chk("ready_back", {31'b0, in_ready}, 32'h1);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);
    // Flush from SKID while offering a beat
    step(1'b1, 32'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h02, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h03, 1'b0, 1'b1, 1'b0);
    chk("flush_data", out_data, 32'h0);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);
    // Reset and flush together while FULL and stalled
    step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h55, 1'b0, 1'b1, 1'b1);
    chk("rst_flush_valid", {31'b0, out_valid}, 32'h0);
    // Hold while EMPTY after a beat leaves
    step(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'(i % 2), 1'b0, 1'b0);
    chk("hold_data", out_data, 32'h66);
    // Random traffic with occasional flush
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 199) == 0), 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
